// File: rtl/uart_fb_loader.sv
// rtl/uart_fb_loader.sv - UART (8N1) RGB565 pixel receiver driving a framebuffer BRAM write port
//
// Purpose: receives byte pairs on ser_rx, forms {hi_byte, lo_byte} pixels and writes them to
// consecutive framebuffer addresses 0..FB_DEPTH-1, wrapping back to 0. A long idle line
// (IDLE_CLKS cycles) re-aligns the host to pixel 0 and drops any pending high byte.
//
// Optional feature macro: UART_FB_LOADER_ACK_EN - when defined, each frame_done sends the
// byte 0x06 on ser_tx (8N1, BAUD). When not defined, ser_tx is tied high.
//
// Ports:
//   clk        in   system clock
//   resetn     in   asynchronous active-low reset
//   ser_rx     in   UART receive line, idle high, asynchronous to clk
//   ser_tx     out  UART transmit line (ack byte only)
//   fb_wen     out  one-cycle write strobe per pixel
//   fb_waddr   out  write address, holds its last value between writes
//   fb_wdata   out  RGB565 pixel {hi_byte, lo_byte}
//   frame_done out  one-cycle pulse together with the write to FB_DEPTH-1
//   frame_err  out  one-cycle pulse on a stop-bit framing error
module uart_fb_loader #(
  parameter int CLK_HZ    = 27000000,
  parameter int BAUD      = 115200,
  parameter int ADDR_W    = 14,
  parameter int FB_DEPTH  = 16200,
  parameter int IDLE_CLKS = 270000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ser_rx,
  output logic              ser_tx,
  output logic              fb_wen,
  output logic [ADDR_W-1:0] fb_waddr,
  output logic [15:0]       fb_wdata,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int CPB    = CLK_HZ / BAUD;
  localparam int HALF   = CPB / 2;
  localparam int CNT_W  = $clog2(CPB + 1);
  localparam int IDLE_W = $clog2(IDLE_CLKS + 1);

  localparam logic [CNT_W-1:0]  CPB_M1    = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0]  HALF_M1   = CNT_W'(HALF - 1);
  localparam logic [IDLE_W-1:0] IDLE_M1   = IDLE_W'(IDLE_CLKS - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_CLKS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } rx_state_e;

  rx_state_e          state_q;
  logic               rx_s1_q, rx_s2_q, rx_s3_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         bit_idx_q;
  logic [7:0]         shift_q;
  logic [7:0]         hi_q;
  logic               phase_lo_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [IDLE_W-1:0]  idle_cnt_q;
  logic               fb_wen_q, frame_done_q, frame_err_q;
  logic [ADDR_W-1:0]  fb_waddr_q;
  logic [15:0]        fb_wdata_q;

  logic start_edge_d;
  logic resync_d;

  // rx_s3_q is the previous synchronised sample; 1 -> 0 marks a start edge.
  assign start_edge_d = rx_s3_q & ~rx_s2_q;

  // The cycle in which the idle counter would reach IDLE_CLKS. A start edge in that same
  // cycle still resynchronises, because the line was high right up to the edge.
  assign resync_d = (state_q == S_IDLE) && (idle_cnt_q == IDLE_M1) &&
                    (rx_s2_q || start_edge_d);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_s3_q      <= 1'b1;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      hi_q         <= '0;
      phase_lo_q   <= 1'b0;
      addr_q       <= '0;
      idle_cnt_q   <= '0;
      fb_wen_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      fb_waddr_q   <= '0;
      fb_wdata_q   <= '0;
    end else begin
      rx_s1_q      <= ser_rx;
      rx_s2_q      <= rx_s1_q;
      rx_s3_q      <= rx_s2_q;
      fb_wen_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (resync_d) begin
            addr_q     <= '0;
            phase_lo_q <= 1'b0;
          end
          if (start_edge_d) begin
            idle_cnt_q <= '0;
            cnt_q      <= '0;
            state_q    <= S_START;
          end else if (rx_s2_q && (idle_cnt_q != IDLE_MAX)) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end

        S_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            // Line back high at mid start bit: treat as a glitch, no byte and no error.
            state_q   <= rx_s2_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_DATA: begin
          if (cnt_q == CPB_M1) begin
            cnt_q   <= '0;
            shift_q <= {rx_s2_q, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_STOP: begin
          if (cnt_q == CPB_M1) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
            if (!rx_s2_q) begin
              frame_err_q <= 1'b1;
            end else if (!phase_lo_q) begin
              hi_q       <= shift_q;
              phase_lo_q <= 1'b1;
            end else begin
              fb_wen_q     <= 1'b1;
              fb_wdata_q   <= {hi_q, shift_q};
              fb_waddr_q   <= addr_q;
              frame_done_q <= (addr_q == LAST_ADDR);
              addr_q       <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
              phase_lo_q   <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fb_wen     = fb_wen_q;
  assign fb_waddr   = fb_waddr_q;
  assign fb_wdata   = fb_wdata_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

`ifdef UART_FB_LOADER_ACK_EN
  // Ack transmitter: start bit goes out the cycle after frame_done. tx_sh_q holds the
  // remaining data bits plus the stop bit; a frame_done while busy is ignored.
  logic             tx_busy_q;
  logic             ser_tx_q;
  logic [3:0]       tx_bits_q;
  logic [8:0]       tx_sh_q;
  logic [CNT_W-1:0] tx_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_busy_q <= 1'b0;
      ser_tx_q  <= 1'b1;
      tx_bits_q <= '0;
      tx_sh_q   <= '1;
      tx_cnt_q  <= '0;
    end else if (!tx_busy_q) begin
      if (frame_done_q) begin
        tx_busy_q <= 1'b1;
        ser_tx_q  <= 1'b0;
        tx_sh_q   <= {1'b1, 8'h06};
        tx_bits_q <= 4'd9;
        tx_cnt_q  <= '0;
      end
    end else if (tx_cnt_q == CPB_M1) begin
      tx_cnt_q <= '0;
      if (tx_bits_q == 4'd0) begin
        tx_busy_q <= 1'b0;
      end else begin
        ser_tx_q  <= tx_sh_q[0];
        tx_sh_q   <= {1'b1, tx_sh_q[8:1]};
        tx_bits_q <= tx_bits_q - 1'b1;
      end
    end else begin
      tx_cnt_q <= tx_cnt_q + 1'b1;
    end
  end

  assign ser_tx = ser_tx_q;
`else
  assign ser_tx = 1'b1;
`endif

endmodule

// File: tb/tb_uart_fb_loader.sv
// tb/tb_uart_fb_loader.sv - directed self-checking bench for uart_fb_loader
module tb_uart_fb_loader;

  localparam int CPB       = 8;
  localparam int ADDR_W    = 14;
  localparam int FB_DEPTH  = 6;
  localparam int IDLE_CLKS = 400;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              ser_rx = 1'b1;
  logic              ser_tx;
  logic              fb_wen;
  logic [ADDR_W-1:0] fb_waddr;
  logic [15:0]       fb_wdata;
  logic              frame_done;
  logic              frame_err;

  uart_fb_loader #(
    .CLK_HZ   (800),
    .BAUD     (100),
    .ADDR_W   (ADDR_W),
    .FB_DEPTH (FB_DEPTH),
    .IDLE_CLKS(IDLE_CLKS)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ser_rx    (ser_rx),
    .ser_tx    (ser_tx),
    .fb_wen    (fb_wen),
    .fb_waddr  (fb_waddr),
    .fb_wdata  (fb_wdata),
    .frame_done(frame_done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int                wen_cnt = 0;
  int                err_cnt = 0;
  int                done_cnt = 0;
  int                tx_low_cnt = 0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [15:0]       last_data = '0;
  logic              last_done = 1'b0;
  int                tx_t = -1;
  logic [9:0]        tx_got = '0;

  // Observation on the falling edge, away from the register updates.
  always @(negedge clk) begin
    if (fb_wen) begin
      wen_cnt   = wen_cnt + 1;
      last_addr = fb_waddr;
      last_data = fb_wdata;
      last_done = frame_done;
    end
    if (frame_err) err_cnt = err_cnt + 1;
    if (frame_done) done_cnt = done_cnt + 1;
    if (!ser_tx) tx_low_cnt = tx_low_cnt + 1;
    if (frame_done) tx_t = 0;
    else if (tx_t >= 0) tx_t = tx_t + 1;
    if (tx_t >= 5 && ((tx_t - 5) % CPB) == 0 && ((tx_t - 5) / CPB) < 10)
      tx_got[(tx_t - 5) / CPB] = ser_tx;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    ser_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    ser_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    ser_rx = 1'b1;
  endtask

  task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo);
    send_byte(hi, 1'b1);
    send_byte(lo, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] h, l;
    int         wen_before;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_wen", 32'(fb_wen), 32'd0);
    check("rst_waddr", 32'(fb_waddr), 32'd0);
    check("rst_wdata", 32'(fb_wdata), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_tx", 32'(ser_tx), 32'd1);
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    // A high byte followed by reset must be forgotten
    send_byte(8'h77, 1'b1);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst2_wen", 32'(fb_wen), 32'd0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    // First pixel
    send_pixel(8'h12, 8'h34);
    check("p0_count", 32'(wen_cnt), 32'd1);
    check("p0_addr", 32'(last_addr), 32'd0);
    check("p0_data", 32'(last_data), 32'h1234);
    check("p0_err", 32'(err_cnt), 32'd0);

    // Short low glitch: shorter than half a bit, no byte, no error
    @(negedge clk);
    ser_rx = 1'b0;
    repeat (2) @(negedge clk);
    ser_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_wen", 32'(wen_cnt), 32'd1);
    check("glitch_err", 32'(err_cnt), 32'd0);

    // Framing error, then a clean pixel at the next address
    send_byte(8'hAB, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("ferr_count", 32'(err_cnt), 32'd1);
    check("ferr_wen", 32'(wen_cnt), 32'd1);
    send_pixel(8'hCD, 8'hEF);
    check("p1_count", 32'(wen_cnt), 32'd2);
    check("p1_addr", 32'(last_addr), 32'd1);
    check("p1_data", 32'(last_data), 32'hCDEF);

    // Idle resync drops the pending 0x11 and restarts at address 0
    send_byte(8'h11, 1'b1);
    repeat (IDLE_CLKS + 50) @(negedge clk);
    send_pixel(8'h22, 8'h33);
    check("rs_count", 32'(wen_cnt), 32'd3);
    check("rs_addr", 32'(last_addr), 32'd0);
    check("rs_data", 32'(last_data), 32'h2233);

    // Fill the rest of the frame and wrap
    for (int i = 1; i <= FB_DEPTH; i++) begin
      h = 8'h50 + 8'(i);
      l = 8'hC0 + 8'(i);
      wen_before = wen_cnt;
      send_pixel(h, l);
      check($sformatf("fr%0d_count", i), 32'(wen_cnt - wen_before), 32'd1);
      check($sformatf("fr%0d_addr", i), 32'(last_addr), (i == FB_DEPTH) ? 32'd0 : 32'(i));
      check($sformatf("fr%0d_data", i), 32'(last_data), 32'({h, l}));
      check($sformatf("fr%0d_done", i), 32'(last_done), (i == FB_DEPTH - 1) ? 32'd1 : 32'd0);
    end
    check("done_total", 32'(done_cnt), 32'd1);
    check("err_total", 32'(err_cnt), 32'd1);
`ifdef UART_FB_LOADER_ACK_EN
    check("ack_byte", 32'(tx_got), 32'(10'b1_0000_0110_0));
`else
    check("tx_idle", 32'(tx_low_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
